// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped L1 instruction cache.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    FILL,
    RESPOND,
    COOL
  } state_t;

  localparam logic [12:0] READ_TAG    = 13'h1400;
  localparam int          LINE_BYTES  = 64;
  localparam int          LINE_WORDS  = 16;
  localparam int          LINE_BEATS  = 8;
  localparam int          LINE_ADDR_W = 58;

endpackage

// File: rtl/icache_data_array.sv
// Line storage: one 64-bit beat written per cycle during a fill, one 32-bit word
// read per cycle through a registered read address.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int SETS    = 64,
  parameter int INDEX_W = $clog2(SETS)
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [INDEX_W-1:0]            wr_index,
  input  logic [$clog2(LINE_BEATS)-1:0] wr_beat,
  input  logic [63:0]                   wr_data,
  input  logic [INDEX_W-1:0]            rd_index,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic [31:0]                   rd_data
);

  logic [63:0]                   mem [SETS*LINE_BEATS];
  logic [INDEX_W-1:0]            rd_index_q;
  logic [$clog2(LINE_WORDS)-1:0] rd_word_q;
  logic [63:0]                   rd_beat;

  // The read is asynchronous off the registered address, so a beat written on an
  // edge is already visible in the cycle that follows it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wr_index, wr_beat}] <= wr_data;
    end
    rd_index_q <= rd_index;
    rd_word_q  <= rd_word;
  end

  assign rd_beat = mem[{rd_index_q, rd_word_q[$clog2(LINE_WORDS)-1:1]}];
  assign rd_data = rd_word_q[0] ? rd_beat[63:32] : rd_beat[31:0];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: tag/valid arrays and the
// lookup/miss/fill FSM, with line data held in icache_data_array.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int SETS           = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ic_req,
  input  logic [LINE_ADDR_W-1:0]    ic_line_addr,
  input  logic [3:0]                ic_word_select,
  output logic                      ic_ack,
  output logic [31:0]               ic_data_out,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = LINE_ADDR_W - INDEX_W;
  localparam int BEAT_W  = $clog2(LINE_BEATS);

  state_t                    state_q, state_d;
  logic [LINE_ADDR_W-1:0]    line_addr_q, line_addr_d;
  logic [3:0]                word_sel_q, word_sel_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [SETS-1:0]           valid_q, valid_d;
  logic [31:0]               data_hold_q, data_hold_d;
  logic                      bus_reqcyc_q, bus_reqcyc_d;
  logic [BUS_DATA_WIDTH-1:0] bus_req_q, bus_req_d;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag_q, bus_reqtag_d;
  logic [TAG_W-1:0]          tag_mem [SETS];

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               fill_we;
  logic               fill_last;
  logic [31:0]        rd_data;
  logic               unused_resptag;

  assign index     = line_addr_q[INDEX_W-1:0];
  assign tag       = line_addr_q[LINE_ADDR_W-1:INDEX_W];
  assign hit       = valid_q[index] && (tag_mem[index] == tag);
  assign fill_we   = (state_q == FILL) && bus_respcyc && !reset;
  assign fill_last = fill_we && (beat_q == BEAT_W'(LINE_BEATS - 1));

  // Every beat is consumed on arrival; outside FILL it is simply dropped.
  assign bus_respack    = bus_respcyc;
  assign unused_resptag = ^bus_resptag;

  assign ic_ack      = (state_q == RESPOND);
  assign ic_data_out = ic_ack ? rd_data : data_hold_q;
  assign bus_reqcyc  = bus_reqcyc_q;
  assign bus_req     = bus_req_q;
  assign bus_reqtag  = bus_reqtag_q;

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    word_sel_d   = word_sel_q;
    beat_d       = beat_q;
    valid_d      = valid_q;
    data_hold_d  = data_hold_q;
    bus_reqcyc_d = bus_reqcyc_q;
    bus_req_d    = bus_req_q;
    bus_reqtag_d = bus_reqtag_q;
    case (state_q)
      IDLE: begin
        if (ic_req) begin
          line_addr_d = ic_line_addr;
          word_sel_d  = ic_word_select;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          state_d = RESPOND;
        end else begin
          state_d      = MISS_REQ;
          bus_reqcyc_d = 1'b1;
          bus_req_d    = BUS_DATA_WIDTH'({line_addr_q, {$clog2(LINE_BYTES){1'b0}}});
          bus_reqtag_d = BUS_TAG_WIDTH'(READ_TAG);
        end
      end
      MISS_REQ: begin
        if (bus_reqack) begin
          bus_reqcyc_d = 1'b0;
          beat_d       = '0;
          state_d      = FILL;
        end
      end
      FILL: begin
        if (bus_respcyc) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BEAT_W'(LINE_BEATS - 1)) begin
            valid_d[index] = 1'b1;
            state_d        = RESPOND;
          end
        end
      end
      RESPOND: begin
        data_hold_d = rd_data;
        state_d     = COOL;
      end
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      valid_q      <= '0;
      data_hold_q  <= '0;
      bus_reqcyc_q <= 1'b0;
      bus_req_q    <= '0;
      bus_reqtag_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      valid_q      <= valid_d;
      data_hold_q  <= data_hold_d;
      bus_reqcyc_q <= bus_reqcyc_d;
      bus_req_q    <= bus_req_d;
      bus_reqtag_q <= bus_reqtag_d;
    end
  end

  // Request latches and the tag array carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    line_addr_q <= line_addr_d;
    word_sel_q  <= word_sel_d;
    if (fill_last) begin
      tag_mem[index] <= tag;
    end
  end

  icache_data_array #(
    .SETS (SETS)
  ) u_data_array (
    .clk      (clk),
    .we       (fill_we),
    .wr_index (index),
    .wr_beat  (beat_q),
    .wr_data  (bus_resp),
    .rd_index (index),
    .rd_word  (word_sel_q),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: each fetch is driven by applyStimulus,
// which also plays the memory bus; results are compared to hand-computed values.
module tb_instruction_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        ic_req;
  logic [57:0] ic_line_addr;
  logic [3:0]  ic_word_select;
  logic        ic_ack;
  logic [31:0] ic_data_out;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;

  int tests_run    = 0;
  int tests_failed = 0;

  int          r_reqs, r_acks, r_ack_cycle, r_respack_bad, r_reqcyc_after_reset;
  logic [63:0] r_req_addr;
  logic [12:0] r_req_tag;
  logic [31:0] r_data;
  logic        r_timeout;

  instruction_cache dut (
    .clk            (clk),
    .reset          (reset),
    .ic_req         (ic_req),
    .ic_line_addr   (ic_line_addr),
    .ic_word_select (ic_word_select),
    .ic_ack         (ic_ack),
    .ic_data_out    (ic_data_out),
    .bus_reqcyc     (bus_reqcyc),
    .bus_req        (bus_req),
    .bus_reqtag     (bus_reqtag),
    .bus_reqack     (bus_reqack),
    .bus_respcyc    (bus_respcyc),
    .bus_resp       (bus_resp),
    .bus_resptag    (bus_resptag),
    .bus_respack    (bus_respack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, observed, expected);
    end
  endtask

  // Memory image: word w of line L holds {(L-0x40)[23:0], w[7:0]}, so line 0x40 word w == w.
  function automatic logic [31:0] word_val(input logic [57:0] line, input int w);
    logic [57:0] rel;
    rel = line - 58'h40;
    return {rel[23:0], 8'(w)};
  endfunction

  // Issues one fetch at a negedge and serves the bus until things go quiet.
  task automatic applyStimulus(input logic [57:0] line, input logic [3:0] word, input int ack_delay,
                               input int gap, input int reset_beat, input int hold);
    int   phase, wait_cnt, gap_cnt, beat, hold_cnt, settle;
    logic reset_fired, acked;
    r_reqs = 0; r_acks = 0; r_ack_cycle = -1; r_respack_bad = 0; r_reqcyc_after_reset = 0;
    r_req_addr = '0; r_req_tag = '0; r_data = '0; r_timeout = 1'b1;
    phase = 0; wait_cnt = 0; gap_cnt = 0; beat = 0; hold_cnt = 0; settle = 0;
    reset_fired = 1'b0; acked = 1'b0;
    ic_req = 1'b1; ic_line_addr = line; ic_word_select = word;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (bus_respack !== bus_respcyc) r_respack_bad++;
      if (reset_fired && bus_reqcyc) r_reqcyc_after_reset++;
      if (ic_ack) begin
        r_acks++;
        if (!acked) begin
          r_ack_cycle = c;
          r_data      = ic_data_out;
          hold_cnt    = hold;
          acked       = 1'b1;
        end
      end
      if (acked && hold_cnt == 0) ic_req = 1'b0;
      else if (acked) hold_cnt--;
      reset = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
      case (phase)
        0: if (bus_reqcyc) begin
          r_reqs++;
          r_req_addr = bus_req;
          r_req_tag  = bus_reqtag;
          wait_cnt   = ack_delay;
          phase      = 1;
        end
        1: if (wait_cnt > 1) wait_cnt--;
           else begin
             bus_reqack = 1'b1;
             phase      = 2;
           end
        2: if (gap_cnt > 0) gap_cnt--;
           else begin
             bus_respcyc = 1'b1;
             bus_resp    = {word_val(line, 2*beat + 1), word_val(line, 2*beat)};
             if (beat == reset_beat) begin
               reset       = 1'b1;
               ic_req      = 1'b0;
               reset_fired = 1'b1;
             end
             beat++;
             gap_cnt = gap;
             if (beat == 8) begin
               phase = 0;
               beat  = 0;
             end
           end
        default: phase = 0;
      endcase
      if (phase == 0 && (acked || reset_fired)) settle++;
      else settle = 0;
      if (settle >= 4) begin
        r_timeout = 1'b0;
        break;
      end
    end
    ic_req = 1'b0; reset = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
  endtask

  task automatic checkTxn(input string name, input int exp_reqs, input logic [63:0] exp_addr,
                          input int exp_acks, input logic [31:0] exp_data, input int exp_cycle);
    checkOutput({name, "_timeout"}, 64'(r_timeout), 64'(0));
    checkOutput({name, "_reqs"}, 64'(r_reqs), 64'(exp_reqs));
    if (exp_reqs > 0) begin
      checkOutput({name, "_addr"}, r_req_addr, exp_addr);
      checkOutput({name, "_reqtag"}, 64'(r_req_tag), 64'h1400);
    end
    checkOutput({name, "_acks"}, 64'(r_acks), 64'(exp_acks));
    if (exp_acks > 0) begin
      checkOutput({name, "_data"}, 64'(r_data), 64'(exp_data));
      checkOutput({name, "_hold"}, 64'(ic_data_out), 64'(exp_data));
    end
    if (exp_cycle > 0) checkOutput({name, "_latency"}, 64'(r_ack_cycle), 64'(exp_cycle));
    checkOutput({name, "_respack"}, 64'(r_respack_bad), 64'(0));
  endtask

  initial begin
    reset = 1'b1; ic_req = 1'b0; ic_line_addr = '0; ic_word_select = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = 13'h1400;
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", 64'(ic_ack), 64'(0));
    checkOutput("rst_data", 64'(ic_data_out), 64'(0));
    checkOutput("rst_reqcyc", 64'(bus_reqcyc), 64'(0));
    checkOutput("rst_req", bus_req, 64'(0));
    checkOutput("rst_reqtag", 64'(bus_reqtag), 64'(0));
    bus_respcyc = 1'b1; bus_resp = 64'hDEAD_BEEF_0BAD_F00D;
    #1 checkOutput("stale_respack_reset", 64'(bus_respack), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1 checkOutput("stale_respack_idle", 64'(bus_respack), 64'(1));
    @(negedge clk);
    bus_respcyc = 1'b0; bus_resp = '0;
    @(negedge clk);

    applyStimulus(58'h40, 4'd3, 2, 0, -1, 0);
    checkTxn("cold", 1, 64'h1000, 1, 32'h3, 0);
    applyStimulus(58'h40, 4'd15, 2, 0, -1, 0);
    checkTxn("hit", 0, 64'h0, 1, 32'hF, 2);

    applyStimulus(58'h80, 4'd5, 2, 0, -1, 0);
    checkTxn("conflict_b", 1, 64'h2000, 1, 32'h4005, 0);
    applyStimulus(58'h40, 4'd7, 2, 0, -1, 0);
    checkTxn("conflict_a", 1, 64'h1000, 1, 32'h7, 0);

    applyStimulus(58'hC1, 4'd9, 10, 3, -1, 0);
    checkTxn("stall", 1, 64'h3040, 1, 32'h8109, 0);
    applyStimulus(58'hC1, 4'd14, 2, 0, -1, 0);
    checkTxn("stall_w14", 0, 64'h0, 1, 32'h810E, 2);
    applyStimulus(58'hC1, 4'd0, 2, 0, -1, 0);
    checkTxn("stall_w0", 0, 64'h0, 1, 32'h8100, 2);

    applyStimulus(58'h42, 4'd2, 2, 0, 4, 0);
    checkTxn("reset_fill", 1, 64'h1080, 0, 32'h0, 0);
    checkOutput("reset_fill_reqcyc", 64'(r_reqcyc_after_reset), 64'(0));
    checkOutput("reset_fill_data", 64'(ic_data_out), 64'(0));
    applyStimulus(58'h42, 4'd2, 2, 0, -1, 0);
    checkTxn("refetch", 1, 64'h1080, 1, 32'h0202, 0);
    applyStimulus(58'h40, 4'd3, 2, 0, -1, 0);
    checkTxn("invalidated", 1, 64'h1000, 1, 32'h3, 0);

    applyStimulus(58'h42, 4'd11, 2, 0, -1, 1);
    checkTxn("b2b", 0, 64'h0, 1, 32'h020B, 2);
    applyStimulus(58'h42, 4'd12, 2, 0, -1, 0);
    checkTxn("b2b_next", 0, 64'h0, 1, 32'h020C, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
